mem_access_stage: RTL
=====================

# mem_access_stage

Parametrised successor MEM pipeline stage between EX and WB. Drives a variable-latency data memory through a valid/ready request and valid response handshake instead of assuming fixed one-cycle SRAM. Aligns store lanes and sign/zero-extends loads. Flags misaligned accesses, passes HI/LO write-back through, and publishes forwarding and stall information to ID.

## Interface
Parameters:
- `ADDR_W`, 32: address / PC width.
- `DATA_W`, 32: data width. Only 32 is legal; the block asserts at elaboration otherwise.
- `REG_AW`, 5: register-file address width.
- `HILO_W`, 66: width of the HI/LO pass-through bundle, laid out as {hi_we, lo_we, hi, lo}.

Ports:
- `clk` in 1: sole clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `ex_valid` in 1: EX presents an instruction.
- `ex_pc` in ADDR_W.
- `ex_op` in 4: memory op code (package).
- `ex_result` in DATA_W: ALU result; byte address for memory ops.
- `ex_store_data` in DATA_W: unshifted store source.
- `ex_rf_we` in 1.
- `ex_rf_waddr` in REG_AW.
- `ex_hilo` in HILO_W.
- `mem_ready` out 1: stage accepts `ex_*` this cycle.
- `dreq_valid` out 1.
- `dreq_ready` in 1.
- `dreq_addr` out ADDR_W: word-aligned, [1:0]=0.
- `dreq_wstrb` out 4: byte strobes; 0 means read.
- `dreq_wdata` out DATA_W: lane-shifted store data.
- `drsp_valid` in 1.
- `drsp_rdata` in DATA_W.
- `wb_valid` out 1.
- `wb_pc` out ADDR_W.
- `wb_rf_we` out 1.
- `wb_rf_waddr` out REG_AW.
- `wb_rf_wdata` out DATA_W.
- `wb_hilo` out HILO_W.
- `wb_exc_misalign` out 1.
- `fwd_pending` out 1: a load to `wb_rf_waddr` is in flight; ID must stall on match.
- `stallreq` out 1: stage busy with memory.

## Operation
- Op codes: NONE=0, LW=1, LB=2, LBU=3, LH=4, LHU=5, SW=6, SB=7, SH=8. Codes 9..15 are treated as NONE.
- FSM states: EMPTY, PASS, REQ, WAIT, LDONE.
- Accept: `ex_valid && mem_ready` captures all `ex_*` into the stage register.
  - NONE goes to PASS.
  - A misaligned access goes to PASS with rf_we forced 0 and the misalign flag set. Misaligned means: halfword ops with addr[0]=1, word ops with addr[1:0]≠0.
  - Other memory ops go to REQ.
- `mem_ready` = state ∈ {EMPTY, PASS, LDONE}. When in one of these states with no accept, the next state is EMPTY.
- REQ: `dreq_valid`=1 and request fields held stable until `dreq_ready`. On handshake, stores go to PASS and loads go to WAIT.
- WAIT: on `drsp_valid`, extended data is registered and the state goes to LDONE. `drsp_valid` is ignored in every other state.
- Store lanes, with a = addr[1:0]:
  - SB: strobe `4'b0001<<a`, data = byte replicated ×4.
  - SH: strobe `4'b0011<<a`, data = half replicated ×2.
  - SW: strobe `4'b1111`.
- Load extend: select byte a or half a[1], then:
  - LB, LH: sign-extend.
  - LBU, LHU: zero-extend.
  - LW: whole word.
- `wb_valid` = state ∈ {PASS, LDONE}.
  - `wb_rf_wdata`: `ex_result` in PASS, extended load data in LDONE.
  - Stores present `wb_rf_we`=0.
- `wb_hilo` passes through unchanged from the captured bundle. `wb_hilo` is zero when `wb_valid`=0.
- `fwd_pending` = state ∈ {REQ, WAIT} && captured rf_we.
- `stallreq` = state ∈ {REQ, WAIT}.

## Timing
- Reset (asynchronous, `rst`=0):
  - State goes to EMPTY; the stage register clears.
  - All outputs are 0 except `mem_ready`=1.
  - `dreq_valid` drops immediately.
  - A response arriving after reset is ignored.
- Non-memory op: accepted at edge E; `wb_valid` is high in cycle E+1 for exactly one cycle, unless back-to-back accepts keep it high.
- Store: REQ in cycle E+1. With `dreq_ready`=1 it moves to PASS, so `wb_valid` is high in cycle E+2.
- Load, best case: REQ E+1, WAIT E+2 with `drsp_valid` in that cycle, LDONE E+3. Minimum EX-to-WB latency is 3 cycles.
- Latency beyond that equals the extra `dreq_ready`-low cycles plus the extra response wait cycles.
- At most one outstanding request; no new accept while in REQ or WAIT.
- WB never back-pressures. PASS and LDONE last exactly one cycle unless a new accept reloads the stage.
- A simultaneous accept in PASS/LDONE and presentation to WB is legal: the old result is shown this cycle and the new one is captured at the edge.

## Structure
- Package `mem_pkg`: the op-code enum, the FSM state enum, and HILO_W field offsets.
- Sub-module `load_extend` (combinational): op, a[1:0], rdata → extended word. It is reused by future cache refill paths.
- Store lane logic stays inline.

## Test plan
- ALU pass-through: accept NONE, result=0x1234_5678, waddr=7 → next cycle `wb_valid`=1, `wb_rf_wdata`=0x1234_5678, `wb_rf_we`=1.
- LB sign: addr=0x103, rdata=0x80FF_FFFF, `dreq_ready`/`drsp_valid` immediate → `dreq_addr`=0x100, `dreq_wstrb`=0, `wb_rf_wdata`=0xFFFF_FF80 at E+3. The same access as LBU gives 0x0000_0080.
- SH: addr=0x202, data=0x0000_BEEF, `dreq_ready` low 2 cycles → `dreq_wstrb`=1100, `dreq_wdata`=0xBEEF_BEEF held 3 cycles; `wb_valid` one cycle after the handshake with `wb_rf_we`=0.
- Misalign: LW addr=0x6 → no `dreq_valid`; `wb_valid`=1 at E+1 with `wb_exc_misalign`=1 and `wb_rf_we`=0.
- Slow load: `drsp_valid` 5 cycles late → `stallreq` and `fwd_pending` high through WAIT, `mem_ready`=0, and `ex_valid` pulses are not taken.
- Reset in WAIT: `rst` low mid-load, then `drsp_valid` pulses → all outputs 0, state EMPTY, no `wb_valid`.

Source files
------------

// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - op codes, FSM states and HI/LO bundle layout for the MEM stage
package mem_pkg;

  typedef enum logic [3:0] {
    OP_NONE = 4'd0,
    OP_LW   = 4'd1,
    OP_LB   = 4'd2,
    OP_LBU  = 4'd3,
    OP_LH   = 4'd4,
    OP_LHU  = 4'd5,
    OP_SW   = 4'd6,
    OP_SB   = 4'd7,
    OP_SH   = 4'd8
  } mem_op_e;

  typedef enum logic [2:0] {
    ST_EMPTY = 3'd0,
    ST_PASS  = 3'd1,
    ST_REQ   = 3'd2,
    ST_WAIT  = 3'd3,
    ST_LDONE = 3'd4
  } mem_state_e;

  // HI/LO bundle is {hi_we, lo_we, hi, lo}
  localparam int HILO_LO_LSB = 0;
  localparam int HILO_HI_LSB = HILO_LO_LSB + 32;
  localparam int HILO_LO_WE  = HILO_HI_LSB + 32;
  localparam int HILO_HI_WE  = HILO_LO_WE + 1;

  function automatic logic op_is_load(input logic [3:0] op);
    case (op)
      OP_LW, OP_LB, OP_LBU, OP_LH, OP_LHU: op_is_load = 1'b1;
      default:                             op_is_load = 1'b0;
    endcase
  endfunction

  function automatic logic op_is_store(input logic [3:0] op);
    case (op)
      OP_SW, OP_SB, OP_SH: op_is_store = 1'b1;
      default:             op_is_store = 1'b0;
    endcase
  endfunction

  function automatic logic op_is_half(input logic [3:0] op);
    case (op)
      OP_LH, OP_LHU, OP_SH: op_is_half = 1'b1;
      default:              op_is_half = 1'b0;
    endcase
  endfunction

  function automatic logic op_is_word(input logic [3:0] op);
    case (op)
      OP_LW, OP_SW: op_is_word = 1'b1;
      default:      op_is_word = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/load_extend.sv
// rtl/load_extend.sv - selects the addressed load lane and sign/zero-extends it
module load_extend
  import mem_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [1:0]  a,
  input  logic [31:0] rdata,
  output logic [31:0] ext
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Pick the addressed byte/half, then extend according to the load flavour
  always_comb begin
    byte_sel = rdata[7:0];
    half_sel = a[1] ? rdata[31:16] : rdata[15:0];
    ext      = rdata;
    case (a)
      2'd1:    byte_sel = rdata[15:8];
      2'd2:    byte_sel = rdata[23:16];
      2'd3:    byte_sel = rdata[31:24];
      default: byte_sel = rdata[7:0];
    endcase
    case (op)
      OP_LB:   ext = {{24{byte_sel[7]}}, byte_sel};
      OP_LBU:  ext = {24'd0, byte_sel};
      OP_LH:   ext = {{16{half_sel[15]}}, half_sel};
      OP_LHU:  ext = {16'd0, half_sel};
      default: ext = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// rtl/mem_access_stage.sv - MEM pipeline stage with valid/ready data-memory handshake
module mem_access_stage
  import mem_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int HILO_W = 66
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_valid,
  input  logic [ADDR_W-1:0] ex_pc,
  input  logic [3:0]        ex_op,
  input  logic [DATA_W-1:0] ex_result,
  input  logic [DATA_W-1:0] ex_store_data,
  input  logic              ex_rf_we,
  input  logic [REG_AW-1:0] ex_rf_waddr,
  input  logic [HILO_W-1:0] ex_hilo,
  output logic              mem_ready,
  output logic              dreq_valid,
  input  logic              dreq_ready,
  output logic [ADDR_W-1:0] dreq_addr,
  output logic [3:0]        dreq_wstrb,
  output logic [DATA_W-1:0] dreq_wdata,
  input  logic              drsp_valid,
  input  logic [DATA_W-1:0] drsp_rdata,
  output logic              wb_valid,
  output logic [ADDR_W-1:0] wb_pc,
  output logic              wb_rf_we,
  output logic [REG_AW-1:0] wb_rf_waddr,
  output logic [DATA_W-1:0] wb_rf_wdata,
  output logic [HILO_W-1:0] wb_hilo,
  output logic              wb_exc_misalign,
  output logic              fwd_pending,
  output logic              stallreq
);

  if (DATA_W != 32) begin : g_bad_data_w
    $error("mem_access_stage: DATA_W must be 32");
  end
  if (HILO_W != HILO_HI_WE + 1) begin : g_bad_hilo_w
    $error("mem_access_stage: HILO_W does not match the HI/LO bundle layout");
  end

  mem_state_e        state, state_nxt;
  logic              accept;
  logic              ex_load, ex_store, ex_misalign;
  logic [3:0]        ex_wstrb;
  logic [DATA_W-1:0] ex_wdata;

  logic [ADDR_W-1:0] r_pc;
  logic [3:0]        r_op;
  logic [DATA_W-1:0] r_result;
  logic [DATA_W-1:0] r_wdata;
  logic [3:0]        r_wstrb;
  logic              r_rf_we;
  logic              r_misalign;
  logic              r_store;
  logic [REG_AW-1:0] r_waddr;
  logic [HILO_W-1:0] r_hilo;
  logic [DATA_W-1:0] r_load_data;
  logic [DATA_W-1:0] ext_data;

  // Decode the incoming op and pre-shift store lanes so the request is stable from REQ entry
  always_comb begin
    ex_load     = op_is_load(ex_op);
    ex_store    = op_is_store(ex_op);
    ex_misalign = (op_is_half(ex_op) && ex_result[0]) ||
                  (op_is_word(ex_op) && (ex_result[1:0] != 2'b00));
    ex_wstrb    = 4'b0000;
    ex_wdata    = '0;
    case (ex_op)
      OP_SB: begin
        ex_wstrb = 4'b0001 << ex_result[1:0];
        ex_wdata = {4{ex_store_data[7:0]}};
      end
      OP_SH: begin
        ex_wstrb = 4'b0011 << ex_result[1:0];
        ex_wdata = {2{ex_store_data[15:0]}};
      end
      OP_SW: begin
        ex_wstrb = 4'b1111;
        ex_wdata = ex_store_data;
      end
      default: ;
    endcase
  end

  // State register; reset abandons any in-flight request or response
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_EMPTY;
    else      state <= state_nxt;
  end

  // Next state and status flags; only one memory request is ever outstanding
  always_comb begin
    state_nxt  = state;
    mem_ready  = 1'b0;
    dreq_valid = 1'b0;
    stallreq   = 1'b0;
    wb_valid   = 1'b0;
    case (state)
      ST_EMPTY, ST_PASS, ST_LDONE: begin
        mem_ready = 1'b1;
        wb_valid  = (state != ST_EMPTY);
        if (ex_valid) state_nxt = ((ex_load || ex_store) && !ex_misalign) ? ST_REQ : ST_PASS;
        else          state_nxt = ST_EMPTY;
      end
      ST_REQ: begin
        dreq_valid = 1'b1;
        stallreq   = 1'b1;
        if (dreq_ready) state_nxt = r_store ? ST_PASS : ST_WAIT;
      end
      ST_WAIT: begin
        stallreq = 1'b1;
        if (drsp_valid) state_nxt = ST_LDONE;
      end
      default: state_nxt = ST_EMPTY;
    endcase
  end

  assign accept = ex_valid && mem_ready;

  // Capture EX on accept; latch the extended load word when the response lands
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pc        <= '0;
      r_op        <= '0;
      r_result    <= '0;
      r_wdata     <= '0;
      r_wstrb     <= '0;
      r_rf_we     <= 1'b0;
      r_misalign  <= 1'b0;
      r_store     <= 1'b0;
      r_waddr     <= '0;
      r_hilo      <= '0;
      r_load_data <= '0;
    end else begin
      if (accept) begin
        r_pc       <= ex_pc;
        r_op       <= ex_op;
        r_result   <= ex_result;
        r_wdata    <= ex_wdata;
        r_wstrb    <= ex_wstrb;
        r_rf_we    <= ex_rf_we && !ex_misalign && !ex_store;
        r_misalign <= ex_misalign;
        r_store    <= ex_store;
        r_waddr    <= ex_rf_waddr;
        r_hilo     <= ex_hilo;
      end
      if (state == ST_WAIT && drsp_valid) r_load_data <= ext_data;
    end
  end

  load_extend u_load_extend (
    .op    (r_op),
    .a     (r_result[1:0]),
    .rdata (drsp_rdata),
    .ext   (ext_data)
  );

  assign dreq_addr       = dreq_valid ? {r_result[ADDR_W-1:2], 2'b00} : '0;
  assign dreq_wstrb      = dreq_valid ? r_wstrb : 4'b0000;
  assign dreq_wdata      = dreq_valid ? r_wdata : '0;

  assign wb_pc           = wb_valid ? r_pc : '0;
  assign wb_rf_we        = wb_valid && r_rf_we;
  assign wb_rf_waddr     = wb_valid ? r_waddr : '0;
  assign wb_rf_wdata     = !wb_valid ? '0 : ((state == ST_LDONE) ? r_load_data : r_result);
  assign wb_hilo         = wb_valid ? r_hilo : '0;
  assign wb_exc_misalign = wb_valid && r_misalign;
  assign fwd_pending     = stallreq && r_rf_we;

endmodule
